tlb_lookup_unit: RTL

- Translation lookaside buffer placed in front of the page-table walker.
- Takes virtual-address requests from the testbench side and returns the physical address.
  - Hit: returns it directly from a small fully-associative array.
  - Miss: issues a walk request to the downstream paging system and refills the array from its answer.
- Upstream and walker handshakes are four-phase request/ACK, matching the paging system's bus protocol.

---
 rtl/paging_pkg.sv | 22 ++
 rtl/tlb_victim_select.sv | 29 ++
 rtl/tlb_lookup_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/paging_pkg.sv
// Shared paging constants, TLB controller states and the TLB entry layout.
package paging_pkg;

   localparam int PKG_ADDR_W    = 32;
   localparam int PKG_PAGE_BITS = 12;
   localparam int PKG_VPN_W     = PKG_ADDR_W - PKG_PAGE_BITS;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WALK_REQ,
      WALK_REL,
      RESPOND
   } tlb_state_e;

   typedef struct packed {
      logic                 valid;
      logic [PKG_VPN_W-1:0] vpn;
      logic [PKG_VPN_W-1:0] pfn;
   } tlb_entry_t;

endpackage

// File: rtl/tlb_victim_select.sv
// Refill victim choice: lowest-index invalid entry, else a round-robin pointer
// that only advances when a refill evicts a valid entry.
module tlb_victim_select #(
   parameter int ENTRIES = 8,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ENTRIES-1:0] valid,
   input  logic               refill,
   output logic [IDX_W-1:0]   victim
);

   logic [IDX_W-1:0] rr_ptr;

   // Walk downward so the lowest invalid index is the last one written.
   always_comb begin
      victim = rr_ptr;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid[i]) victim = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                 rr_ptr <= '0;
      else if (refill && &valid)  rr_ptr <= rr_ptr + 1'b1;
   end

endmodule

// File: rtl/tlb_lookup_unit.sv
// Fully-associative TLB with four-phase upstream and walker handshakes.
// Define TLB_STATS_EN to add saturating hit/miss counters (Stat_hits, Stat_misses).
module tlb_lookup_unit
   import paging_pkg::*;
#(
   parameter  int ENTRIES   = 8,
   parameter  int ADDR_W    = PKG_ADDR_W,
   parameter  int PAGE_BITS = PKG_PAGE_BITS,
   localparam int VW        = ADDR_W - PAGE_BITS,
   localparam int IDX_W     = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              VA_request,
   input  logic [ADDR_W-1:0] VA_address,
   output logic              VA_ACK,
   output logic [ADDR_W-1:0] PA_address,
   output logic              PA_hit,
   output logic              Walk_request,
   output logic [VW-1:0]     Walk_vpn,
   input  logic              Walk_ACK,
   input  logic [VW-1:0]     Walk_pfn,
   input  logic              Flush
`ifdef TLB_STATS_EN
   ,
   output logic [31:0]       Stat_hits,
   output logic [31:0]       Stat_misses
`endif
);

   tlb_state_e           state, state_nxt;
   tlb_entry_t           tlb_q [ENTRIES];
   logic [VW-1:0]        vpn_q, pfn_q, hit_pfn;
   logic [PAGE_BITS-1:0] off_q;
   logic [ADDR_W-1:0]    pa_q;
   logic                 hit_q, va_ack_q, hit;
   logic [ENTRIES-1:0]   valid_vec;
   logic [IDX_W-1:0]     victim;
   logic                 refill;

   // Refill never duplicates a tag, so at most one entry drives hit_pfn.
   always_comb begin
      hit     = 1'b0;
      hit_pfn = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         valid_vec[i] = tlb_q[i].valid;
         if (tlb_q[i].valid && tlb_q[i].vpn == vpn_q) begin
            hit     = 1'b1;
            hit_pfn = tlb_q[i].pfn;
         end
      end
   end

   assign refill = (state == WALK_REQ) && Walk_ACK;

   tlb_victim_select #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_victim (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (valid_vec),
      .refill (refill),
      .victim (victim)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (!Flush && VA_request) state_nxt = LOOKUP;
         LOOKUP:   state_nxt = hit ? RESPOND : WALK_REQ;
         WALK_REQ: if (Walk_ACK)    state_nxt = WALK_REL;
         WALK_REL: if (!Walk_ACK)   state_nxt = RESPOND;
         RESPOND:  if (!VA_request) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vpn_q    <= '0;
         off_q    <= '0;
         pfn_q    <= '0;
         pa_q     <= '0;
         hit_q    <= 1'b0;
         va_ack_q <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) tlb_q[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Flush) begin
                  for (int i = 0; i < ENTRIES; i++) tlb_q[i].valid <= 1'b0;
               end else if (VA_request) begin
                  vpn_q <= VA_address[ADDR_W-1:PAGE_BITS];
                  off_q <= VA_address[PAGE_BITS-1:0];
               end
            end
            LOOKUP: if (hit) begin
               pa_q  <= {hit_pfn, off_q};
               hit_q <= 1'b1;
            end
            WALK_REQ: if (Walk_ACK) begin
               pfn_q         <= Walk_pfn;
               tlb_q[victim] <= '{valid: 1'b1, vpn: vpn_q, pfn: Walk_pfn};
            end
            WALK_REL: if (!Walk_ACK) begin
               pa_q  <= {pfn_q, off_q};
               hit_q <= 1'b0;
            end
            // ACK follows the request so it drops on the edge that sees release.
            RESPOND: va_ack_q <= VA_request;
            default: ;
         endcase
      end
   end

   assign VA_ACK       = va_ack_q;
   assign PA_address   = pa_q;
   assign PA_hit       = hit_q;
   assign Walk_request = (state == WALK_REQ);
   assign Walk_vpn     = Walk_request ? vpn_q : '0;

`ifdef TLB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Stat_hits   <= '0;
         Stat_misses <= '0;
      end else if (state == LOOKUP) begin
         if (hit && Stat_hits != 32'hFFFF_FFFF)    Stat_hits   <= Stat_hits + 1'b1;
         if (!hit && Stat_misses != 32'hFFFF_FFFF) Stat_misses <= Stat_misses + 1'b1;
      end
   end
`endif

endmodule
